// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet framer.
package eth_pkg;

    // Framer FSM states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_PAD     = 3'd3,
        ST_DROP    = 3'd4
    } state_t;

    localparam int          ETH_HDR_BYTES   = 14;
    localparam int          VLAN_TAG_BYTES  = 4;
    localparam logic [15:0] TPID_VLAN       = 16'h8100;
    localparam logic [15:0] ETHERTYPE_IPV4  = 16'h0800;
    localparam int          MIN_FRAME_BYTES = 60;

    // Header length in bytes, with or without the 802.1Q tag
    function automatic int hdr_bytes(input int vlan_en);
        return ETH_HDR_BYTES + ((vlan_en != 0) ? VLAN_TAG_BYTES : 0);
    endfunction

    // Smallest payload that still yields a minimum-size frame (FCS excluded)
    function automatic int min_payload(input int vlan_en);
        return MIN_FRAME_BYTES - hdr_bytes(vlan_en);
    endfunction

endpackage

// File: rtl/eth_hdr_gen.sv
// Selects header word i_idx from the latched header fields, MSB first.
module eth_hdr_gen
    import eth_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int VLAN_EN = 0
) (
    input  logic [47:0]       i_dst,
    input  logic [47:0]       i_src,
    input  logic [15:0]       i_etype,
    input  logic [11:0]       i_vid,
    input  logic [4:0]        i_idx,
    output logic [DATA_W-1:0] o_word
);

    // Both layouts are left-aligned in a 144-bit vector so word k always
    // starts at bit 143 - k*DATA_W.
    localparam int HDR_MAX_BITS = (ETH_HDR_BYTES + VLAN_TAG_BYTES) * 8;
    localparam int SLOTS        = HDR_MAX_BITS / DATA_W;

    logic [HDR_MAX_BITS-1:0] w_hdr_vlan;
    logic [HDR_MAX_BITS-1:0] w_hdr_plain;
    logic [HDR_MAX_BITS-1:0] w_hdr;

    assign w_hdr_vlan  = {i_dst, i_src, TPID_VLAN, 4'h0, i_vid, i_etype};
    assign w_hdr_plain = {i_dst, i_src, i_etype, 32'h0000_0000};
    assign w_hdr       = (VLAN_EN != 0) ? w_hdr_vlan : w_hdr_plain;

    // Word multiplexer over every slot of the header vector
    always_comb begin
        o_word = '0;
        for (int k = 0; k < SLOTS; k++) begin
            o_word = (i_idx == 5'(k)) ? w_hdr[HDR_MAX_BITS-1-k*DATA_W -: DATA_W] : o_word;
        end
    end

endmodule

// File: rtl/eth_framer.sv
// Ethernet framer: prepends an L2 header to a payload stream, pads short
// packets to the minimum frame size and truncates oversize packets.
module eth_framer
    import eth_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int VLAN_EN     = 0,
    parameter int MAX_PAYLOAD = 1500
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [47:0]       cfg_dst_mac,
    input  logic [47:0]       cfg_src_mac,
    input  logic [15:0]       cfg_ethertype,
    input  logic [11:0]       cfg_vid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready,
    output logic [31:0]       frame_cnt,
    output logic              err_oversize
);

    generate
        if (!(DATA_W == 8 || DATA_W == 16)) begin : g_bad_data_w
            $error("eth_framer: DATA_W must be 8 or 16");
        end
    endgenerate

    localparam int          HDR_WORDS    = hdr_bytes(VLAN_EN) * 8 / DATA_W;
    localparam logic [4:0]  LAST_HDR_IDX = 5'(HDR_WORDS - 1);
    localparam logic [10:0] BYTES_PER_W  = 11'(DATA_W / 8);
    localparam logic [10:0] MIN_PAY      = 11'(min_payload(VLAN_EN));
    localparam logic [10:0] MAX_PAY      = 11'(MAX_PAYLOAD);

    state_t             r_state;
    logic [47:0]        r_dst;
    logic [47:0]        r_src;
    logic [15:0]        r_etype;
    logic [11:0]        r_vid;
    logic [4:0]         r_hdr_idx;
    logic [10:0]        r_cnt;
    logic [31:0]        r_frame_cnt;
    logic               r_err;

    logic [DATA_W-1:0]  w_hdr_word;
    logic [10:0]        w_cnt_next;
    logic               w_s_ready;
    logic               w_m_valid;
    logic               w_m_last;
    logic [DATA_W-1:0]  w_m_data;
    logic               w_acc_in;
    logic               w_acc_out;

    eth_hdr_gen #(
        .DATA_W  (DATA_W),
        .VLAN_EN (VLAN_EN)
    ) u_hdr_gen (
        .i_dst   (r_dst),
        .i_src   (r_src),
        .i_etype (r_etype),
        .i_vid   (r_vid),
        .i_idx   (r_hdr_idx),
        .o_word  (w_hdr_word)
    );

    assign w_cnt_next = r_cnt + BYTES_PER_W;
    assign w_acc_in   = s_valid & w_s_ready;
    assign w_acc_out  = w_m_valid & m_ready;

    // Output steering per state; payload is a zero-latency pass-through
    always_comb begin
        w_s_ready = 1'b0;
        w_m_valid = 1'b0;
        w_m_last  = 1'b0;
        w_m_data  = '0;
        case (r_state)
            ST_HDR: begin
                w_m_valid = 1'b1;
                w_m_data  = w_hdr_word;
            end
            ST_PAYLOAD: begin
                w_m_valid = s_valid;
                w_m_data  = s_data;
                w_s_ready = m_ready;
                w_m_last  = s_valid & (s_last ? (w_cnt_next >= MIN_PAY)
                                              : (w_cnt_next >= MAX_PAY));
            end
            ST_PAD: begin
                w_m_valid = 1'b1;
                w_m_last  = (w_cnt_next >= MIN_PAY);
            end
            ST_DROP: begin
                w_s_ready = 1'b1;
            end
            default: begin
                w_s_ready = 1'b0;
            end
        endcase
    end

    assign s_ready      = w_s_ready;
    assign m_valid      = w_m_valid;
    assign m_last       = w_m_last;
    assign m_data       = w_m_data;
    assign frame_cnt    = r_frame_cnt;
    assign err_oversize = r_err;

    // Frame sequencing FSM, byte counter, cfg snapshot and frame counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_dst       <= 48'h0;
            r_src       <= 48'h0;
            r_etype     <= 16'h0;
            r_vid       <= 12'h0;
            r_hdr_idx   <= 5'd0;
            r_cnt       <= 11'd0;
            r_frame_cnt <= 32'd0;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_acc_out && w_m_last) begin
                r_frame_cnt <= r_frame_cnt + 32'd1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (s_valid) begin
                        // Snapshot cfg so mid-frame changes cannot leak in
                        r_dst     <= cfg_dst_mac;
                        r_src     <= cfg_src_mac;
                        r_etype   <= cfg_ethertype;
                        r_vid     <= cfg_vid;
                        r_hdr_idx <= 5'd0;
                        r_cnt     <= 11'd0;
                        r_state   <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (m_ready) begin
                        r_hdr_idx <= r_hdr_idx + 5'd1;
                        if (r_hdr_idx == LAST_HDR_IDX) begin
                            r_state <= ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (w_acc_in) begin
                        r_cnt <= w_cnt_next;
                        if (s_last) begin
                            r_state <= (w_cnt_next >= MIN_PAY) ? ST_IDLE : ST_PAD;
                        end else if (w_cnt_next >= MAX_PAY) begin
                            r_err   <= 1'b1;
                            r_state <= ST_DROP;
                        end
                    end
                end
                ST_PAD: begin
                    if (m_ready) begin
                        r_cnt <= w_cnt_next;
                        if (w_cnt_next >= MIN_PAY) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_DROP: begin
                    if (s_valid && s_last) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_framer.sv
// Table-driven bench for eth_framer: three configurations (8-bit plain,
// 16-bit VLAN, 8-bit with MAX_PAYLOAD=64) checked against an expected
// byte stream built from the header constants and the payload pattern.
module tb_eth_framer;
    import eth_pkg::*;

    localparam logic [47:0] DST = 48'h02_11_22_33_44_55;
    localparam logic [47:0] SRC = 48'h02_AA_BB_CC_DD_EE;
    localparam logic [11:0] VID = 12'h123;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [47:0] cfg_dst, cfg_src;
    logic [15:0] cfg_et;
    logic [11:0] cfg_vid;
    logic [15:0] s_data;
    logic        s_valid, s_last, m_ready;
    logic [1:0]  sel;

    logic        s_ready0, m_valid0, m_last0, err0;
    logic [7:0]  m_data0;
    logic [31:0] fc0;
    logic        s_ready1, m_valid1, m_last1, err1;
    logic [15:0] m_data1;
    logic [31:0] fc1;
    logic        s_ready2, m_valid2, m_last2, err2;
    logic [7:0]  m_data2;
    logic [31:0] fc2;

    eth_framer #(.DATA_W(8), .VLAN_EN(0), .MAX_PAYLOAD(1500)) u_d0 (
        .clk(clk), .rst(rst), .cfg_dst_mac(cfg_dst), .cfg_src_mac(cfg_src),
        .cfg_ethertype(cfg_et), .cfg_vid(cfg_vid), .s_data(s_data[7:0]),
        .s_valid(s_valid && sel == 2'd0), .s_last(s_last), .s_ready(s_ready0),
        .m_data(m_data0), .m_valid(m_valid0), .m_last(m_last0), .m_ready(m_ready),
        .frame_cnt(fc0), .err_oversize(err0));

    eth_framer #(.DATA_W(16), .VLAN_EN(1), .MAX_PAYLOAD(1500)) u_d1 (
        .clk(clk), .rst(rst), .cfg_dst_mac(cfg_dst), .cfg_src_mac(cfg_src),
        .cfg_ethertype(cfg_et), .cfg_vid(cfg_vid), .s_data(s_data),
        .s_valid(s_valid && sel == 2'd1), .s_last(s_last), .s_ready(s_ready1),
        .m_data(m_data1), .m_valid(m_valid1), .m_last(m_last1), .m_ready(m_ready),
        .frame_cnt(fc1), .err_oversize(err1));

    eth_framer #(.DATA_W(8), .VLAN_EN(0), .MAX_PAYLOAD(64)) u_d2 (
        .clk(clk), .rst(rst), .cfg_dst_mac(cfg_dst), .cfg_src_mac(cfg_src),
        .cfg_ethertype(cfg_et), .cfg_vid(cfg_vid), .s_data(s_data[7:0]),
        .s_valid(s_valid && sel == 2'd2), .s_last(s_last), .s_ready(s_ready2),
        .m_data(m_data2), .m_valid(m_valid2), .m_last(m_last2), .m_ready(m_ready),
        .frame_cnt(fc2), .err_oversize(err2));

    logic        mon_sready, mon_valid, mon_last, mon_err;
    logic [15:0] mon_data;
    logic [31:0] mon_fc;

    // Route the selected DUT's outputs to the monitor
    always_comb begin
        mon_sready = 1'b0; mon_valid = 1'b0; mon_last = 1'b0; mon_err = 1'b0;
        mon_data = 16'h0; mon_fc = 32'h0;
        case (sel)
            2'd0: begin mon_sready = s_ready0; mon_valid = m_valid0; mon_last = m_last0;
                        mon_err = err0; mon_data = {8'h00, m_data0}; mon_fc = fc0; end
            2'd1: begin mon_sready = s_ready1; mon_valid = m_valid1; mon_last = m_last1;
                        mon_err = err1; mon_data = m_data1; mon_fc = fc1; end
            2'd2: begin mon_sready = s_ready2; mon_valid = m_valid2; mon_last = m_last2;
                        mon_err = err2; mon_data = {8'h00, m_data2}; mon_fc = fc2; end
            default: mon_sready = 1'b0;
        endcase
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int hdr_words(input int s);
        return (s == 1) ? 9 : 14;
    endfunction

    function automatic int max_words(input int s);
        return (s == 2) ? 64 : ((s == 1) ? 750 : 1500);
    endfunction

    function automatic logic [15:0] pat(input int s, input int p);
        if (s == 1) return 16'hA000 + 16'(p);
        else        return {8'h00, 8'(8'h30 + p)};
    endfunction

    // Expected output word k for an n-word packet on configuration s
    function automatic logic [15:0] exp_word(input int s, input int k, input int n);
        logic [143:0] h;
        int p;
        if (s == 1) h = {DST, SRC, TPID_VLAN, 4'h0, VID, ETHERTYPE_IPV4};
        else        h = {DST, SRC, ETHERTYPE_IPV4, 32'h0};
        if (k < hdr_words(s)) begin
            if (s == 1) return h[143-16*k -: 16];
            else        return {8'h00, h[143-8*k -: 8]};
        end
        p = k - hdr_words(s);
        if (p < n && p < max_words(s)) return pat(s, p);
        return 16'h0000;
    endfunction

    logic [15:0] cap_q[$];
    int err_seen, stab_bad, sready_bad, post_bad;
    bit timeout;

    // Send one n-word packet on configuration s and capture the frame
    task automatic run_packet(input logic [1:0] s, input int n, input bit stall);
        int in_idx, cyc;
        bit done, seen_last, prev_stall, acc_in, acc_out;
        logic [15:0] prev_data;
        logic prev_last;
        cap_q.delete();
        err_seen = 0; stab_bad = 0; sready_bad = 0; post_bad = 0; timeout = 0;
        sel = s; cfg_dst = DST; cfg_src = SRC; cfg_et = ETHERTYPE_IPV4; cfg_vid = VID;
        in_idx = 0; cyc = 0; done = 0; seen_last = 0; prev_stall = 0;
        prev_data = 16'h0; prev_last = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (cyc >= 1) begin
                cfg_dst = ~DST; cfg_src = ~SRC; cfg_et = 16'hBEEF; cfg_vid = 12'hFFF;
            end
            s_valid = (in_idx < n);
            s_data  = (in_idx < n) ? pat(s, in_idx) : 16'h0;
            s_last  = (in_idx == n - 1);
            m_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (mon_err) err_seen++;
            if (prev_stall && (!mon_valid || mon_data !== prev_data || mon_last !== prev_last))
                stab_bad++;
            if (in_idx >= n && mon_sready) sready_bad++;
            if (seen_last && mon_valid) post_bad++;
            acc_in  = s_valid && mon_sready;
            acc_out = mon_valid && m_ready;
            if (acc_out && !seen_last) begin
                cap_q.push_back(mon_data);
                if (mon_last) seen_last = 1;
            end
            prev_stall = mon_valid && !m_ready;
            prev_data  = mon_data;
            prev_last  = mon_last;
            if (acc_in) in_idx++;
            cyc++;
            if (seen_last && in_idx >= n) done = 1;
            if (cyc > 3000) begin timeout = 1; done = 1; end
        end
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
            #1;
            if (mon_err) err_seen++;
        end
    endtask

    typedef struct {
        int          sel;
        int          nwords;
        bit          stall;
        int          exp_words;
        int          exp_err;
        int          spot_idx;
        logic [15:0] spot_val;
    } vec_t;

    vec_t vecs[14];
    int   exp_fc[3];

    initial begin
        vecs[0]  = '{0, 100, 0, 114, 0, 12, 16'h0008};
        vecs[1]  = '{0,  10, 0,  60, 0, 13, 16'h0000};
        vecs[2]  = '{0,  10, 1,  60, 0, 23, 16'h0039};
        vecs[3]  = '{0, 100, 1, 114, 0,  0, 16'h0002};
        vecs[4]  = '{0,  46, 0,  60, 0, 59, 16'h005D};
        vecs[5]  = '{0,  45, 0,  60, 0, 59, 16'h0000};
        vecs[6]  = '{1,   4, 0,  30, 0,  6, 16'h8100};
        vecs[7]  = '{1,   4, 1,  30, 0,  7, 16'h0123};
        vecs[8]  = '{1,  21, 0,  30, 0,  8, 16'h0800};
        vecs[9]  = '{1,  25, 1,  34, 0, 33, 16'hA018};
        vecs[10] = '{2,  80, 0,  78, 1, 77, 16'h006F};
        vecs[11] = '{2,  80, 1,  78, 1, 14, 16'h0030};
        vecs[12] = '{2,  64, 0,  78, 0, 77, 16'h006F};
        vecs[13] = '{2,  63, 0,  77, 0, 76, 16'h006E};
        exp_fc = '{0, 0, 0};

        rst = 1'b1; sel = 2'd0; s_valid = 1'b0; s_last = 1'b0; s_data = 16'h0; m_ready = 1'b1;
        cfg_dst = DST; cfg_src = SRC; cfg_et = ETHERTYPE_IPV4; cfg_vid = VID;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0; #1;
        check("reset_d0_outs", {28'h0, s_ready0, m_valid0, m_last0, err0}, 32'h0);
        check("reset_d1_outs", {28'h0, s_ready1, m_valid1, m_last1, err1}, 32'h0);
        check("reset_d2_outs", {28'h0, s_ready2, m_valid2, m_last2, err2}, 32'h0);
        check("reset_fc0", fc0, 32'h0);
        check("reset_fc1", fc1, 32'h0);
        check("reset_fc2", fc2, 32'h0);

        // Reset while payload byte 20 is on the bus: frame must be abandoned
        begin
            int in_idx, cyc;
            bit saw_last;
            in_idx = 0; cyc = 0; saw_last = 0; sel = 2'd0;
            while (in_idx < 20 && cyc < 400) begin
                @(negedge clk);
                s_valid = 1'b1; s_data = pat(0, in_idx); s_last = 1'b0; m_ready = 1'b1;
                #1;
                if (mon_valid && mon_last) saw_last = 1;
                if (mon_sready) in_idx++;
                cyc++;
            end
            check("midrst_reached_byte20", 32'(in_idx), 32'd20);
            @(negedge clk);
            s_data = pat(0, in_idx); rst = 1'b1;
            #1;
            if (mon_valid && mon_last) saw_last = 1;
            @(negedge clk);
            rst = 1'b0; s_valid = 1'b0;
            #1;
            check("midrst_no_mlast", {31'h0, saw_last}, 32'h0);
            check("midrst_mvalid_idle", {31'h0, m_valid0}, 32'h0);
            check("midrst_fc0", fc0, 32'h0);
        end

        for (int i = 0; i < 14; i++) begin
            int s, lim;
            s = vecs[i].sel;
            run_packet(2'(s), vecs[i].nwords, vecs[i].stall);
            exp_fc[s]++;
            check($sformatf("v%0d_timeout", i), {31'h0, timeout}, 32'h0);
            check($sformatf("v%0d_len", i), 32'(cap_q.size()), 32'(vecs[i].exp_words));
            lim = (cap_q.size() < vecs[i].exp_words) ? cap_q.size() : vecs[i].exp_words;
            for (int k = 0; k < lim; k++)
                check($sformatf("v%0d_w%0d", i, k), {16'h0, cap_q[k]},
                      {16'h0, exp_word(s, k, vecs[i].nwords)});
            if (vecs[i].spot_idx < cap_q.size())
                check($sformatf("v%0d_spot%0d", i, vecs[i].spot_idx),
                      {16'h0, cap_q[vecs[i].spot_idx]}, {16'h0, vecs[i].spot_val});
            else
                check($sformatf("v%0d_spot_present", i), 32'(cap_q.size()), 32'(vecs[i].exp_words));
            check($sformatf("v%0d_err_pulses", i), 32'(err_seen), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_stall_stable", i), 32'(stab_bad), 32'h0);
            check($sformatf("v%0d_sready_low_after_input", i), 32'(sready_bad), 32'h0);
            check($sformatf("v%0d_no_valid_after_last", i), 32'(post_bad), 32'h0);
            check($sformatf("v%0d_frame_cnt", i), mon_fc, 32'(exp_fc[s]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_framer.md
ETH_FRAMER -- requirements
Module: eth_framer

Interface
REQ-001 The module SHALL have the parameter DATA_W, default 8, giving the stream width in bits; only 8 and 16 are legal, and elaboration SHALL fail for any other value.
REQ-002 The module SHALL have the parameter VLAN_EN, default 0; when 1, it inserts an 802.1Q tag (TPID 0x8100, PCP=0, DEI=0, VID=cfg_vid).
REQ-003 The module SHALL have the parameter MAX_PAYLOAD, default 1500, giving the maximum payload bytes per frame.
REQ-004 The module SHALL have the following ports:
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- cfg_dst_mac  in  48  destination MAC
- cfg_src_mac  in  48  source MAC
- cfg_ethertype  in  16  EtherType, nominally 0x0800
- cfg_vid  in  12  VLAN ID, used only when VLAN_EN=1
- s_data  in  DATA_W  RTP payload word
- s_valid  in  1  payload word valid
- s_last  in  1  last payload word of the packet
- s_ready  out  1  framer accepts the payload word
- m_data  out  DATA_W  Ethernet frame word, MSB first on the wire, FCS excluded
- m_valid  out  1  frame word valid
- m_last  out  1  last word of the frame
- m_ready  in  1  downstream accepts the frame word
- frame_cnt  out  32  count of completed frames
- err_oversize  out  1  one-cycle pulse when a packet is truncated

Function
REQ-005 Handshakes: a transfer SHALL occur on a cycle with valid&ready; m_valid, m_data and m_last SHALL hold stable until accepted.
REQ-006 The block SHALL implement these FSM states: IDLE, HDR, PAYLOAD, PAD, DROP.
REQ-007 IDLE SHALL drive s_ready=0 and m_valid=0; on s_valid=1, the block SHALL latch all cfg_* inputs and go to HDR next cycle.
REQ-008 cfg_* changes SHALL NOT affect a frame already in progress.
REQ-009 HDR SHALL emit HDR_BYTES=14+4*VLAN_EN header bytes as HDR_BYTES*8/DATA_W words, in the order dst, src, [0x8100, PCP/DEI/VID], ethertype.
REQ-010 In HDR, s_ready SHALL be 0; HDR SHALL go to PAYLOAD after the final header word is accepted.
REQ-011 In PAYLOAD, the block SHALL pass through combinationally (m_data=s_data, m_valid=s_valid, s_ready=m_ready), with zero latency.
REQ-012 A payload byte counter SHALL be 11 bits, increment by DATA_W/8 per accepted word, and clear on entry to HDR.
REQ-013 MIN_PAYLOAD SHALL be 46-4*VLAN_EN, so every frame is at least 60 bytes.
REQ-014 For an accepted word with s_last=1 and post-increment count >= MIN_PAYLOAD, the block SHALL assert m_last on that word, then go to IDLE.
REQ-015 For an accepted word with s_last=1 and count < MIN_PAYLOAD, the block SHALL leave m_last=0 and go to PAD.
REQ-016 PAD SHALL emit zero words with s_ready=0 until count reaches MIN_PAYLOAD, assert m_last on the final pad word, then go to IDLE.
REQ-017 For an accepted word with s_last=0 that brings count to MAX_PAYLOAD, the block SHALL force m_last=1 on it, pulse err_oversize, and go to DROP.
REQ-018 For a word with s_last=1 and count == MAX_PAYLOAD, REQ-014 SHALL apply with no error.
REQ-019 DROP SHALL drive s_ready=1 and m_valid=0, discard words through the one carrying s_last, then go to IDLE.
REQ-020 frame_cnt SHALL increment by 1 on each accepted m_last word and wrap from 0xFFFFFFFF to 0.
REQ-021 Payload words SHALL be whole; partial last words are out of scope.

Reset
REQ-022 On rst=1 at a clk edge, the state SHALL become IDLE and all counters and latched cfg SHALL clear; s_ready, m_valid, m_last, err_oversize and frame_cnt SHALL read 0 the next cycle.
REQ-023 rst asserted mid-frame SHALL abandon the frame without emitting m_last, and the next frame SHALL start cleanly with HDR.

Structure
REQ-024 A package eth_pkg SHALL hold the state enum, ETH_HDR_BYTES=14, VLAN_TAG_BYTES=4, TPID_VLAN=16'h8100, ETHERTYPE_IPV4=16'h0800, and MIN_FRAME_BYTES=60.
REQ-025 A sub-module eth_hdr_gen SHALL select header word k from the latched cfg; the FSM and counters SHALL remain in eth_framer.

Verification
REQ-026 DATA_W=8, VLAN_EN=0, 100-byte packet, m_ready=1 -> 14 header bytes with bytes 12-13 = 08 00, then 100 payload bytes; m_last on byte 114; frame_cnt=1.
REQ-027 10-byte packet -> 14 header bytes + 10 payload bytes + 36 zero bytes; m_last on byte 60; s_ready=0 throughout PAD.
REQ-028 DATA_W=16, VLAN_EN=1, cfg_vid=0x123 -> header words 6-8 = 8100, 0123, 0800; a 4-word packet pads to 21 payload words (42 bytes).
REQ-029 MAX_PAYLOAD=64, 80-byte packet -> m_last on payload byte 64, err_oversize pulses once, remaining 16 bytes consumed with m_valid=0.
REQ-030 Random m_ready backpressure -> m_data/m_last stable while stalled; byte stream identical to the no-stall case.
REQ-031 rst asserted during payload byte 20 -> no m_last emitted; the next packet frames correctly, with frame_cnt counting only that packet.
